dispatch_mq: RTL and testbench

DISPATCH_MQ -- requirements
Module: dispatch_mq

---
 rtl/dispatch_mq.sv | 191 +++++++++++++++++++
 tb/tb_dispatch_mq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_mq.sv
// Dispatch stage: decodes the IFQ head, renames its destination, and parks it in a
// single registered slot that drains into one of NUM_Q execution queues.
module dispatch_mq #(
  parameter int NUM_Q = 4,
  parameter int TAG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ifq_inst,
  input  logic [31:0]       ifq_pc_out,
  input  logic              ifq_empty,
  output logic              ifq_rd_en,
  output logic [31:0]       ifq_jump_branch_addr,
  output logic              ifq_jump_branch_valid,
  input  logic [TAG_W-1:0]  tagfifo_tag,
  input  logic              tagfifo_empty,
  output logic              tagfifo_ren,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  input  logic [TAG_W-1:0]  rs_tag,
  input  logic [TAG_W-1:0]  rt_tag,
  input  logic              rs_pending,
  input  logic              rt_pending,
  output logic              rst_wen,
  output logic [4:0]        rst_waddr,
  output logic [TAG_W-1:0]  rst_wtag,
  input  logic              cdb_valid,
  input  logic              cdb_branch,
  input  logic              cdb_branch_taken,
  input  logic [TAG_W-1:0]  cdb_tag,
  output logic [31:0]       equeue_inst,
  output logic [TAG_W-1:0]  equeue_tag,
  output logic [TAG_W-1:0]  equeue_rstag,
  output logic [TAG_W-1:0]  equeue_rttag,
  output logic              equeue_rsvalid,
  output logic              equeue_rtvalid,
  output logic [NUM_Q-1:0]  equeue_en,
  input  logic [NUM_Q-1:0]  equeue_ready
);
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] BR_WAIT = 1'b1;

  localparam logic [1:0] Q_INT  = 2'd0;
  localparam logic [1:0] Q_LS   = 2'd1;
  localparam logic [1:0] Q_MULT = 2'd2;
  localparam logic [1:0] Q_DIV  = 2'd3;

  typedef struct packed {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] rstag;
    logic [TAG_W-1:0] rttag;
    logic             rsv;
    logic             rtv;
    logic [1:0]       q;
  } slot_t;

  logic [0:0]  state;
  logic        slot_vld;
  slot_t       slot, slot_in;
  logic [31:0] br_target;

  logic [5:0]  opcode, funct;
  logic        queued, is_branch, is_jump, has_dest;
  logic [1:0]  qsel;
  logic [4:0]  dest;
  logic        xfer, slot_free, accept, acc_q;
  logic [31:0] pc4, br_tgt, j_tgt;

  assign opcode  = ifq_inst[31:26];
  assign funct   = ifq_inst[5:0];
  assign rs_addr = ifq_inst[25:21];
  assign rt_addr = ifq_inst[20:16];

  always_comb begin
    queued    = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    has_dest  = 1'b0;
    qsel      = Q_INT;
    dest      = 5'd0;
    case (opcode)
      6'h00: begin
        queued   = 1'b1;
        has_dest = 1'b1;
        dest     = ifq_inst[15:11];
        case (funct)
          6'h18, 6'h19: qsel = Q_MULT;
          6'h1A, 6'h1B: qsel = Q_DIV;
          default:      qsel = Q_INT;
        endcase
      end
      6'h08, 6'h09, 6'h0C, 6'h0D: begin
        queued   = 1'b1;
        has_dest = 1'b1;
        dest     = ifq_inst[20:16];
      end
      6'h23: begin
        queued   = 1'b1;
        has_dest = 1'b1;
        qsel     = Q_LS;
        dest     = ifq_inst[20:16];
      end
      6'h2B: begin
        queued = 1'b1;
        qsel   = Q_LS;
      end
      6'h04, 6'h05: begin
        queued    = 1'b1;
        is_branch = 1'b1;
      end
      6'h02:   is_jump = 1'b1;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_en
    assign equeue_en[gi] = slot_vld && (int'(slot.q) == gi);
  end

  assign xfer      = |(equeue_en & equeue_ready);
  assign slot_free = !slot_vld || xfer;
  // Jumps and illegal ops never take a tag, so only queued classes wait on the tag FIFO.
  assign accept    = !rst && (state == RUN) && !ifq_empty && slot_free &&
                     (!queued || !tagfifo_empty);
  assign acc_q     = accept && queued;

  assign ifq_rd_en   = accept;
  assign tagfifo_ren = acc_q;
  assign rst_wen     = acc_q && has_dest && (dest != 5'd0);
  assign rst_waddr   = dest;
  assign rst_wtag    = tagfifo_tag;

  assign pc4    = ifq_pc_out + 32'd4;
  assign br_tgt = pc4 + {{14{ifq_inst[15]}}, ifq_inst[15:0], 2'b00};
  assign j_tgt  = {pc4[31:28], ifq_inst[25:0], 2'b00};

  always_comb begin
    slot_in.inst  = ifq_inst;
    slot_in.tag   = tagfifo_tag;
    slot_in.rstag = rs_tag;
    slot_in.rttag = rt_tag;
    slot_in.rsv   = !rs_pending || (cdb_valid && (cdb_tag == rs_tag));
    slot_in.rtv   = !rt_pending || (cdb_valid && (cdb_tag == rt_tag));
    slot_in.q     = qsel;
  end

  assign equeue_inst    = slot.inst;
  assign equeue_tag     = slot.tag;
  assign equeue_rstag   = slot.rstag;
  assign equeue_rttag   = slot.rttag;
  assign equeue_rsvalid = slot.rsv;
  assign equeue_rtvalid = slot.rtv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= RUN;
      slot_vld              <= 1'b0;
      slot                  <= '0;
      br_target             <= 32'd0;
      ifq_jump_branch_valid <= 1'b0;
      ifq_jump_branch_addr  <= 32'd0;
    end else begin
      ifq_jump_branch_valid <= 1'b0;
      if (accept && is_jump) begin
        ifq_jump_branch_valid <= 1'b1;
        ifq_jump_branch_addr  <= j_tgt;
      end
      if (acc_q && is_branch) begin
        state     <= BR_WAIT;
        br_target <= br_tgt;
      end else if (state == BR_WAIT && cdb_valid && cdb_branch) begin
        state <= RUN;
        if (cdb_branch_taken) begin
          ifq_jump_branch_valid <= 1'b1;
          ifq_jump_branch_addr  <= br_target;
        end
      end
      // A fresh load wins over draining; otherwise wake held operands from the CDB.
      if (acc_q) begin
        slot_vld <= 1'b1;
        slot     <= slot_in;
      end else if (xfer) begin
        slot_vld <= 1'b0;
      end else if (slot_vld && cdb_valid) begin
        if (cdb_tag == slot.rstag) slot.rsv <= 1'b1;
        if (cdb_tag == slot.rttag) slot.rtv <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dispatch_mq.sv
// Self-checking bench for dispatch_mq: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_dispatch_mq;
  logic        clk, rst;
  logic [31:0] ifq_inst, ifq_pc_out;
  logic        ifq_empty, ifq_rd_en;
  logic [31:0] ifq_jump_branch_addr;
  logic        ifq_jump_branch_valid;
  logic [5:0]  tagfifo_tag;
  logic        tagfifo_empty, tagfifo_ren;
  logic [4:0]  rs_addr, rt_addr;
  logic [5:0]  rs_tag, rt_tag;
  logic        rs_pending, rt_pending;
  logic        rst_wen;
  logic [4:0]  rst_waddr;
  logic [5:0]  rst_wtag;
  logic        cdb_valid, cdb_branch, cdb_branch_taken;
  logic [5:0]  cdb_tag;
  logic [31:0] equeue_inst;
  logic [5:0]  equeue_tag, equeue_rstag, equeue_rttag;
  logic        equeue_rsvalid, equeue_rtvalid;
  logic [3:0]  equeue_en, equeue_ready;

  int n_checks = 0;
  int n_fail   = 0;

  dispatch_mq #(.NUM_Q(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .ifq_inst(ifq_inst), .ifq_pc_out(ifq_pc_out), .ifq_empty(ifq_empty), .ifq_rd_en(ifq_rd_en),
    .ifq_jump_branch_addr(ifq_jump_branch_addr), .ifq_jump_branch_valid(ifq_jump_branch_valid),
    .tagfifo_tag(tagfifo_tag), .tagfifo_empty(tagfifo_empty), .tagfifo_ren(tagfifo_ren),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_tag(rs_tag), .rt_tag(rt_tag),
    .rs_pending(rs_pending), .rt_pending(rt_pending),
    .rst_wen(rst_wen), .rst_waddr(rst_waddr), .rst_wtag(rst_wtag),
    .cdb_valid(cdb_valid), .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken), .cdb_tag(cdb_tag),
    .equeue_inst(equeue_inst), .equeue_tag(equeue_tag), .equeue_rstag(equeue_rstag), .equeue_rttag(equeue_rttag),
    .equeue_rsvalid(equeue_rsvalid), .equeue_rtvalid(equeue_rtvalid),
    .equeue_en(equeue_en), .equeue_ready(equeue_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic idle_inputs();
    ifq_inst = 32'd0; ifq_pc_out = 32'd0; ifq_empty = 1'b1;
    tagfifo_tag = 6'd0; tagfifo_empty = 1'b0;
    rs_tag = 6'd0; rt_tag = 6'd0; rs_pending = 1'b0; rt_pending = 1'b0;
    cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0; cdb_tag = 6'd0;
    equeue_ready = 4'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; ifq_empty = 1'b0; ifq_inst = rtype(1, 2, 3, 6'h20);
    cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_branch_taken = 1'b1;
    #1;
    n_checks++; if (ifq_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b exp 0", ifq_rd_en); end
    n_checks++; if (tagfifo_ren !== 1'b0) begin n_fail++; $display("FAIL reset_tag_ren: got %b exp 0", tagfifo_ren); end
    n_checks++; if (rst_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rst_wen: got %b exp 0", rst_wen); end
    step();
    n_checks++; if (equeue_en !== 4'b0000) begin n_fail++; $display("FAIL reset_en: got %b exp 0000", equeue_en); end
    n_checks++; if (ifq_jump_branch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_jbv: got %b exp 0", ifq_jump_branch_valid); end
    n_checks++; if (ifq_jump_branch_addr !== 32'd0) begin n_fail++; $display("FAIL reset_jba: got %h exp 0", ifq_jump_branch_addr); end
    n_checks++; if ({equeue_inst, equeue_tag, equeue_rsvalid} !== 39'd0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", {equeue_inst, equeue_tag, equeue_rsvalid}); end
    rst = 1'b0; idle_inputs(); step();
  endtask

  task automatic test_cdb_bypass();
    idle_inputs();
    ifq_empty = 1'b0; ifq_inst = rtype(1, 2, 3, 6'h20); tagfifo_tag = 6'd9;
    rs_pending = 1'b1; rs_tag = 6'd5; cdb_valid = 1'b1; cdb_tag = 6'd5;
    #1;
    n_checks++; if ({rs_addr, rt_addr} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL byp_addr: got %h exp %h", {rs_addr, rt_addr}, {5'd1, 5'd2}); end
    n_checks++; if ({ifq_rd_en, tagfifo_ren, rst_wen} !== 3'b111) begin n_fail++; $display("FAIL byp_pops: got %b exp 111", {ifq_rd_en, tagfifo_ren, rst_wen}); end
    n_checks++; if ({rst_waddr, rst_wtag} !== {5'd3, 6'd9}) begin n_fail++; $display("FAIL byp_rst_write: got %h exp %h", {rst_waddr, rst_wtag}, {5'd3, 6'd9}); end
    step();
    // Second op waits behind the first with rt pending on tag 7.
    ifq_inst = rtype(4, 6, 8, 6'h22); tagfifo_tag = 6'd10; rs_pending = 1'b0;
    rt_pending = 1'b1; rt_tag = 6'd7; cdb_valid = 1'b0; equeue_ready = 4'b0001;
    #1;
    n_checks++; if (equeue_en !== 4'b0001) begin n_fail++; $display("FAIL byp_en: got %b exp 0001", equeue_en); end
    n_checks++; if ({equeue_rsvalid, equeue_rtvalid} !== 2'b11) begin n_fail++; $display("FAIL byp_valid: got %b exp 11", {equeue_rsvalid, equeue_rtvalid}); end
    n_checks++; if ({equeue_tag, equeue_rstag} !== {6'd9, 6'd5}) begin n_fail++; $display("FAIL byp_tags: got %h exp %h", {equeue_tag, equeue_rstag}, {6'd9, 6'd5}); end
    n_checks++; if (equeue_inst !== rtype(1, 2, 3, 6'h20)) begin n_fail++; $display("FAIL byp_inst: got %h exp %h", equeue_inst, rtype(1, 2, 3, 6'h20)); end
    step();
    ifq_empty = 1'b1; equeue_ready = 4'b0000;
    #1;
    n_checks++; if ({equeue_tag, equeue_rttag, equeue_rtvalid} !== {6'd10, 6'd7, 1'b0}) begin n_fail++; $display("FAIL held_rt: got %h exp %h", {equeue_tag, equeue_rttag, equeue_rtvalid}, {6'd10, 6'd7, 1'b0}); end
    cdb_valid = 1'b1; cdb_tag = 6'd7;
    step();
    cdb_valid = 1'b0;
    step();
    n_checks++; if ({equeue_en, equeue_rtvalid} !== 5'b0001_1) begin n_fail++; $display("FAIL held_wake: got %b exp 00011", {equeue_en, equeue_rtvalid}); end
    equeue_ready = 4'b0001;
    step();
    n_checks++; if (equeue_en !== 4'b0000) begin n_fail++; $display("FAIL byp_drain: got %b exp 0000", equeue_en); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    ifq_empty = 1'b0; ifq_inst = itype(6'h23, 2, 4, 16'h0010); tagfifo_tag = 6'd20;
    step();
    ifq_inst = rtype(1, 2, 5, 6'h20); tagfifo_tag = 6'd21;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (equeue_en !== 4'b0010) begin n_fail++; $display("FAIL bp_hold_en[%0d]: got %b exp 0010", i, equeue_en); end
      n_checks++; if (ifq_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold_rd[%0d]: got %b exp 0", i, ifq_rd_en); end
      step();
    end
    equeue_ready = 4'b0010;
    #1;
    n_checks++; if (ifq_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_release_rd: got %b exp 1", ifq_rd_en); end
    step();
    n_checks++; if ({equeue_en, equeue_tag} !== {4'b0001, 6'd21}) begin n_fail++; $display("FAIL bp_next: got %h exp %h", {equeue_en, equeue_tag}, {4'b0001, 6'd21}); end
    ifq_empty = 1'b1; equeue_ready = 4'b1111;
    step();
    idle_inputs();
  endtask

  task automatic test_branch();
    idle_inputs();
    ifq_empty = 1'b0; ifq_inst = itype(6'h04, 1, 2, 16'd4); ifq_pc_out = 32'h100;
    tagfifo_tag = 6'd12; equeue_ready = 4'b0001;
    #1;
    n_checks++; if ({ifq_rd_en, tagfifo_ren, rst_wen} !== 3'b110) begin n_fail++; $display("FAIL br_accept: got %b exp 110", {ifq_rd_en, tagfifo_ren, rst_wen}); end
    step();
    ifq_inst = rtype(1, 2, 5, 6'h20); ifq_pc_out = 32'h104; tagfifo_tag = 6'd13;
    #1;
    n_checks++; if (equeue_en !== 4'b0001) begin n_fail++; $display("FAIL br_en: got %b exp 0001", equeue_en); end
    n_checks++; if ({ifq_rd_en, ifq_jump_branch_valid} !== 2'b00) begin n_fail++; $display("FAIL br_wait1: got %b exp 00", {ifq_rd_en, ifq_jump_branch_valid}); end
    step();
    n_checks++; if ({ifq_rd_en, equeue_en} !== 5'b0_0000) begin n_fail++; $display("FAIL br_wait2: got %b exp 00000", {ifq_rd_en, equeue_en}); end
    cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_branch_taken = 1'b1; cdb_tag = 6'd12;
    #1;
    n_checks++; if (ifq_rd_en !== 1'b0) begin n_fail++; $display("FAIL br_resolve_rd: got %b exp 0", ifq_rd_en); end
    step();
    cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0;
    #1;
    n_checks++; if ({ifq_jump_branch_valid, ifq_jump_branch_addr} !== {1'b1, 32'h114}) begin n_fail++; $display("FAIL br_redirect: got %h exp %h", {ifq_jump_branch_valid, ifq_jump_branch_addr}, {1'b1, 32'h114}); end
    n_checks++; if (ifq_rd_en !== 1'b1) begin n_fail++; $display("FAIL br_run_rd: got %b exp 1", ifq_rd_en); end
    step();
    ifq_empty = 1'b1;
    #1;
    n_checks++; if (ifq_jump_branch_valid !== 1'b0) begin n_fail++; $display("FAIL br_single_pulse: got %b exp 0", ifq_jump_branch_valid); end
    step();
    idle_inputs();
  endtask

  task automatic test_jump_illegal();
    logic [31:0] jinst;
    idle_inputs();
    jinst = {6'h02, 26'h0000040};
    ifq_empty = 1'b0; ifq_inst = jinst; ifq_pc_out = 32'h200;
    #1;
    n_checks++; if ({ifq_rd_en, tagfifo_ren, rst_wen} !== 3'b100) begin n_fail++; $display("FAIL j_accept: got %b exp 100", {ifq_rd_en, tagfifo_ren, rst_wen}); end
    step();
    ifq_inst = {6'h3F, 5'd1, 5'd3, 16'h0}; ifq_pc_out = 32'h204;
    #1;
    n_checks++; if ({ifq_jump_branch_valid, ifq_jump_branch_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL j_redirect: got %h exp %h", {ifq_jump_branch_valid, ifq_jump_branch_addr}, {1'b1, 32'h100}); end
    n_checks++; if ({ifq_rd_en, tagfifo_ren, rst_wen} !== 3'b100) begin n_fail++; $display("FAIL ill_accept: got %b exp 100", {ifq_rd_en, tagfifo_ren, rst_wen}); end
    step();
    ifq_empty = 1'b1;
    #1;
    n_checks++; if ({ifq_jump_branch_valid, equeue_en} !== 5'b0_0000) begin n_fail++; $display("FAIL ill_discard: got %b exp 00000", {ifq_jump_branch_valid, equeue_en}); end
    idle_inputs();
  endtask

  task automatic test_tag_stall();
    idle_inputs();
    ifq_empty = 1'b0; ifq_inst = rtype(1, 2, 0, 6'h18); tagfifo_empty = 1'b1; tagfifo_tag = 6'd30;
    #1;
    n_checks++; if ({ifq_rd_en, tagfifo_ren} !== 2'b00) begin n_fail++; $display("FAIL ts_stall: got %b exp 00", {ifq_rd_en, tagfifo_ren}); end
    step();
    n_checks++; if ({equeue_en, ifq_rd_en} !== 5'b0000_0) begin n_fail++; $display("FAIL ts_still: got %b exp 00000", {equeue_en, ifq_rd_en}); end
    tagfifo_empty = 1'b0;
    #1;
    n_checks++; if ({ifq_rd_en, tagfifo_ren, rst_wen} !== 3'b110) begin n_fail++; $display("FAIL ts_go: got %b exp 110", {ifq_rd_en, tagfifo_ren, rst_wen}); end
    step();
    ifq_empty = 1'b1;
    #1;
    n_checks++; if ({equeue_en, equeue_tag} !== {4'b0100, 6'd30}) begin n_fail++; $display("FAIL ts_en: got %h exp %h", {equeue_en, equeue_tag}, {4'b0100, 6'd30}); end
    equeue_ready = 4'b0100;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_midbranch();
    idle_inputs();
    ifq_empty = 1'b0; ifq_inst = itype(6'h05, 1, 2, 16'hFFFF); ifq_pc_out = 32'h300; tagfifo_tag = 6'd14;
    step();
    ifq_inst = rtype(1, 2, 4, 6'h1A); tagfifo_tag = 6'd15;
    #1;
    n_checks++; if ({equeue_en, ifq_rd_en} !== 5'b0001_0) begin n_fail++; $display("FAIL rb_held: got %b exp 00010", {equeue_en, ifq_rd_en}); end
    rst = 1'b1;
    #1;
    n_checks++; if (ifq_rd_en !== 1'b0) begin n_fail++; $display("FAIL rb_rd_in_rst: got %b exp 0", ifq_rd_en); end
    step();
    n_checks++; if ({equeue_en, ifq_jump_branch_valid, ifq_jump_branch_addr, equeue_inst} !== 69'd0) begin n_fail++; $display("FAIL rb_zero: got %h exp 0", {equeue_en, ifq_jump_branch_valid, ifq_jump_branch_addr, equeue_inst}); end
    rst = 1'b0; cdb_valid = 1'b1; cdb_branch = 1'b1; cdb_branch_taken = 1'b1; cdb_tag = 6'd14;
    #1;
    n_checks++; if (ifq_rd_en !== 1'b1) begin n_fail++; $display("FAIL rb_run: got %b exp 1", ifq_rd_en); end
    step();
    cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_branch_taken = 1'b0; ifq_empty = 1'b1;
    #1;
    n_checks++; if ({ifq_jump_branch_valid, equeue_en} !== 5'b0_1000) begin n_fail++; $display("FAIL rb_no_pulse: got %b exp 01000", {ifq_jump_branch_valid, equeue_en}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++; if ({ifq_jump_branch_valid, equeue_en} !== 5'b0_0000) begin n_fail++; $display("FAIL rb_div_gone: got %b exp 00000", {ifq_jump_branch_valid, equeue_en}); end
    idle_inputs();
  endtask

  // Reference decode: class 0..3 = queue index, 4 = jump, 5 = illegal.
  function automatic void decode(input logic [31:0] i, output int cls, output int dst, output bit br);
    logic [5:0] op = i[31:26];
    logic [5:0] fn = i[5:0];
    cls = 5; dst = 0; br = 1'b0;
    if (op == 6'h00) begin
      cls = (fn == 6'h18 || fn == 6'h19) ? 2 : (fn == 6'h1A || fn == 6'h1B) ? 3 : 0;
      dst = int'(i[15:11]);
    end else if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D}) begin cls = 0; dst = int'(i[20:16]); end
    else if (op == 6'h23) begin cls = 1; dst = int'(i[20:16]); end
    else if (op == 6'h2B) cls = 1;
    else if (op == 6'h04 || op == 6'h05) begin cls = 0; br = 1'b1; end
    else if (op == 6'h02) cls = 4;
  endfunction

  function automatic logic [31:0] rand_inst();
    int k = int'($urandom_range(0, 9));
    int a = int'($urandom_range(0, 7));
    int b = int'($urandom_range(0, 7));
    int d = int'($urandom_range(0, 7));
    case (k)
      0: return rtype(a, b, d, 6'h20);
      1: return rtype(a, b, d, ($urandom % 2 == 0) ? 6'h18 : 6'h19);
      2: return rtype(a, b, d, ($urandom % 2 == 0) ? 6'h1A : 6'h1B);
      3: return itype(($urandom % 2 == 0) ? 6'h08 : 6'h0D, a, b, 16'($urandom));
      4: return itype(6'h23, a, b, 16'($urandom));
      5: return itype(6'h2B, a, b, 16'($urandom));
      6: return itype(($urandom % 2 == 0) ? 6'h04 : 6'h05, a, b, 16'($urandom));
      7: return {6'h02, 26'($urandom)};
      8: return {6'h3F, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit m_wait = 1'b0, m_held = 1'b0, m_jv = 1'b0, m_rsv = 1'b0, m_rtv = 1'b0;
    int m_q = 0;
    logic [31:0] m_inst = 32'd0, m_ja = 32'd0, m_tgt = 32'd0, pc4;
    logic [5:0] m_tag = 6'd0, m_rstag = 6'd0, m_rttag = 6'd0;
    int cls, dst;
    bit br, out, room, pop, tk, nj;
    logic [3:0] exp_en;
    idle_inputs(); rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      ifq_empty = ($urandom % 4 == 0); ifq_inst = rand_inst(); ifq_pc_out = $urandom & 32'hFFFF_FFFC;
      tagfifo_empty = ($urandom % 6 == 0); tagfifo_tag = 6'($urandom);
      rs_tag = 6'($urandom % 8); rt_tag = 6'($urandom % 8);
      rs_pending = 1'($urandom); rt_pending = 1'($urandom);
      cdb_valid = 1'($urandom); cdb_tag = 6'($urandom % 8);
      cdb_branch = ($urandom % 3 == 0); cdb_branch_taken = 1'($urandom);
      equeue_ready = 4'($urandom);
      #1;
      exp_en = m_held ? 4'(1 << m_q) : 4'd0;
      n_checks++; if (equeue_en !== exp_en) begin n_fail++; $display("FAIL rnd_en c%0d: got %b exp %b", c, equeue_en, exp_en); end
      n_checks++; if ({ifq_jump_branch_valid, ifq_jump_branch_addr} !== {m_jv, m_ja}) begin n_fail++; $display("FAIL rnd_redirect c%0d: got %h exp %h", c, {ifq_jump_branch_valid, ifq_jump_branch_addr}, {m_jv, m_ja}); end
      if (m_held) begin
        n_checks++; if ({equeue_inst, equeue_tag, equeue_rstag, equeue_rttag, equeue_rsvalid, equeue_rtvalid} !== {m_inst, m_tag, m_rstag, m_rttag, m_rsv, m_rtv}) begin
          n_fail++; $display("FAIL rnd_slot c%0d: got %h exp %h", c, {equeue_inst, equeue_tag, equeue_rstag, equeue_rttag, equeue_rsvalid, equeue_rtvalid}, {m_inst, m_tag, m_rstag, m_rttag, m_rsv, m_rtv});
        end
      end
      decode(ifq_inst, cls, dst, br);
      out  = m_held && equeue_ready[m_q];
      room = !m_held || out;
      pop  = !m_wait && !ifq_empty && room && (cls > 3 || !tagfifo_empty);
      tk   = pop && cls < 4;
      n_checks++; if ({ifq_rd_en, tagfifo_ren, rst_wen} !== {pop, tk, tk && dst != 0}) begin n_fail++; $display("FAIL rnd_pops c%0d: got %b exp %b", c, {ifq_rd_en, tagfifo_ren, rst_wen}, {pop, tk, tk && dst != 0}); end
      if (tk && dst != 0) begin
        n_checks++; if ({rst_waddr, rst_wtag} !== {5'(dst), tagfifo_tag}) begin n_fail++; $display("FAIL rnd_rst_write c%0d: got %h exp %h", c, {rst_waddr, rst_wtag}, {5'(dst), tagfifo_tag}); end
      end
      pc4 = ifq_pc_out + 32'd4; nj = 1'b0;
      if (pop && cls == 4) begin nj = 1'b1; m_ja = {pc4[31:28], ifq_inst[25:0], 2'b00}; end
      if (m_wait && cdb_valid && cdb_branch) begin
        m_wait = 1'b0;
        if (cdb_branch_taken) begin nj = 1'b1; m_ja = m_tgt; end
      end
      if (tk && br) begin m_wait = 1'b1; m_tgt = pc4 + 32'($signed(ifq_inst[15:0])) * 4; end
      if (tk) begin
        m_held = 1'b1; m_q = cls; m_inst = ifq_inst; m_tag = tagfifo_tag;
        m_rstag = rs_tag; m_rttag = rt_tag;
        m_rsv = !rs_pending || (cdb_valid && cdb_tag == rs_tag);
        m_rtv = !rt_pending || (cdb_valid && cdb_tag == rt_tag);
      end else if (out) begin
        m_held = 1'b0;
      end else if (m_held && cdb_valid) begin
        if (cdb_tag == m_rstag) m_rsv = 1'b1;
        if (cdb_tag == m_rttag) m_rtv = 1'b1;
      end
      m_jv = nj;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cdb_bypass();
    test_backpressure();
    test_branch();
    test_jump_illegal();
    test_tag_stall();
    test_reset_midbranch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
